// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the 3-bit state enum and its encodings, plus a small decode helper.
// Width parameters stay local to seq_ctrl.
package seq_pkg;

    // Sequencer states. These encodings appear directly on the state output,
    // so other blocks and benches may rely on them.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXEC       = 3'd3,
        ST_WRITE_BACK = 3'd4,
        ST_HALT       = 3'd5
    } state_t;

    // True while an instruction is in flight (any of the four pipeline steps).
    function automatic logic is_busy(input state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) ||
               (s == ST_EXEC)  || (s == ST_WRITE_BACK);
    endfunction

endpackage

// File: rtl/seq_ctrl.sv
// seq_ctrl: four-step instruction sequencer (FETCH, DECODE, EXEC, WRITE_BACK)
// with IDLE and HALT parking states, a decode-time opcode/halt latch and a
// saturating retired-instruction counter.
// Optional feature: define SEQ_CTRL_STEP_EN to let step_mode return the
// sequencer to IDLE after every instruction (one instruction per start).
// Reset is synchronous and active-low on rstn.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             load_en,
    input  logic             pc_max,
    input  logic [OP_W-1:0]  op_code,
    input  logic             halt_op,
    input  logic             step_mode,
    output logic             pc_inc,
    output logic             id_ce,
    output logic             acc_ce,
    output logic             rf_we,
    output logic [OP_W-1:0]  op_latch,
    output logic [2:0]       state,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t cur_state;
    state_t nxt_state;
    logic   halt_flag;
    logic   stop_after_wb;
    logic   step_stop;

`ifdef SEQ_CTRL_STEP_EN
    // Single-step: park in IDLE after each instruction so each start runs one.
    assign step_stop = step_mode;
`else
    // Stepping is not built in; step_mode is deliberately left dangling.
    logic unused_step_mode;
    assign unused_step_mode = step_mode;
    assign step_stop        = 1'b0;
`endif

    // A halt request wins over everything else at the end of an instruction.
    assign stop_after_wb = halt_flag || pc_max;

    // State register; rstn forces IDLE from any state, even mid-instruction.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state decision: the four instruction steps always run to completion.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (start && !load_en) begin
                    nxt_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                nxt_state = ST_DECODE;
            end
            ST_DECODE: begin
                nxt_state = ST_EXEC;
            end
            ST_EXEC: begin
                nxt_state = ST_WRITE_BACK;
            end
            ST_WRITE_BACK: begin
                if (stop_after_wb) begin
                    nxt_state = ST_HALT;
                end else if (load_en || step_stop) begin
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (load_en) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // Moore strobes decoded from the state register; pc_inc is also gated by
    // pc_max so the program counter never wraps past its last address.
    always_comb begin
        pc_inc = 1'b0;
        id_ce  = 1'b0;
        acc_ce = 1'b0;
        rf_we  = 1'b0;
        case (cur_state)
            ST_FETCH:      pc_inc = !pc_max;
            ST_DECODE:     id_ce  = 1'b1;
            ST_EXEC:       acc_ce = 1'b1;
            ST_WRITE_BACK: rf_we  = 1'b1;
            default:       ;
        endcase
    end

    assign state  = cur_state;
    assign busy   = is_busy(cur_state);
    assign halted = (cur_state == ST_HALT);

    // Decode latch: opcode and halt flag are captured in DECODE; the halt flag
    // is dropped as a new instruction begins so it only affects its own one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_latch  <= '0;
            halt_flag <= 1'b0;
        end else if (cur_state == ST_DECODE) begin
            op_latch  <= op_code;
            halt_flag <= halt_op;
        end else if (nxt_state == ST_FETCH) begin
            halt_flag <= 1'b0;
        end
    end

    // Retired-instruction counter: one count per WRITE_BACK, sticking at
    // all-ones; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            instr_cnt <= '0;
        end else if ((cur_state == ST_WRITE_BACK) && (instr_cnt != CNT_MAX)) begin
            instr_cnt <= instr_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: a directed vector table, a saturation run and a long
// randomized run checked against an instruction-level reference model.
// Two instances share stimulus: default widths and CNT_W=2.
module tb_seq_ctrl;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rstn, start, load_en, pc_max, halt_op, step_mode;
    logic [2:0] op_code;

    logic       a_pc_inc, a_id_ce, a_acc_ce, a_rf_we, a_busy, a_halted;
    logic [2:0] a_op_latch, a_state;
    logic [7:0] a_cnt;
    logic       b_pc_inc, b_id_ce, b_acc_ce, b_rf_we, b_busy, b_halted;
    logic [2:0] b_op_latch, b_state;
    logic [1:0] b_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: run mode (0 idle, 1 running, 2 halted), step within
    // the instruction, unbounded retire count, latched opcode and halt flag.
    int       m_mode  = 0;
    int       m_phase = 0;
    int       m_cnt   = 0;
    logic [2:0] m_op  = '0;
    bit       m_hflag = 0;

    typedef struct packed {
        logic       rstn, start, load_en, pc_max;
        logic [2:0] op;
        logic       halt;
        logic [2:0] st;
        logic [5:0] fl;
        logic [2:0] oplat;
        logic [7:0] c8;
        logic [1:0] c2;
    } vec_t;

    vec_t vecs [36];

    always #5 clk = ~clk;

    seq_ctrl #(.CNT_W(8), .OP_W(3)) dut (
        .clk(clk), .rstn(rstn), .start(start), .load_en(load_en),
        .pc_max(pc_max), .op_code(op_code), .halt_op(halt_op),
        .step_mode(step_mode), .pc_inc(a_pc_inc), .id_ce(a_id_ce),
        .acc_ce(a_acc_ce), .rf_we(a_rf_we), .op_latch(a_op_latch),
        .state(a_state), .busy(a_busy), .halted(a_halted), .instr_cnt(a_cnt)
    );

    seq_ctrl #(.CNT_W(2), .OP_W(3)) dut_small (
        .clk(clk), .rstn(rstn), .start(start), .load_en(load_en),
        .pc_max(pc_max), .op_code(op_code), .halt_op(halt_op),
        .step_mode(step_mode), .pc_inc(b_pc_inc), .id_ce(b_id_ce),
        .acc_ce(b_acc_ce), .rf_we(b_rf_we), .op_latch(b_op_latch),
        .state(b_state), .busy(b_busy), .halted(b_halted), .instr_cnt(b_cnt)
    );

    function automatic vec_t mk(int r, int s, int l, int p, int o, int h,
                                int st, logic [5:0] fl, int op, int c8, int c2);
        vec_t v;
        v.rstn = 1'(r); v.start = 1'(s); v.load_en = 1'(l); v.pc_max = 1'(p);
        v.op = 3'(o); v.halt = 1'(h); v.st = 3'(st); v.fl = fl;
        v.oplat = 3'(op); v.c8 = 8'(c8); v.c2 = 2'(c2);
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic l,
                                 input logic p, input logic [2:0] o,
                                 input logic h, input logic stp);
        @(negedge clk);
        rstn = r; start = s; load_en = l; pc_max = p;
        op_code = o; halt_op = h; step_mode = stp;
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] e_st,
                               input logic [5:0] e_fl, input logic [2:0] e_op,
                               input logic [7:0] e_c8, input logic [1:0] e_c2);
        checkField({tag, ".state"}, 32'(a_state), 32'(e_st));
        checkField({tag, ".strobes"},
                   32'({a_pc_inc, a_id_ce, a_acc_ce, a_rf_we, a_busy, a_halted}),
                   32'(e_fl));
        checkField({tag, ".op_latch"}, 32'(a_op_latch), 32'(e_op));
        checkField({tag, ".cnt8"}, 32'(a_cnt), 32'(e_c8));
        checkField({tag, ".cnt2"}, 32'(b_cnt), 32'(e_c2));
    endtask

    // Advance the reference model by one clock using the inputs now applied.
    task automatic modelStep();
        if (!rstn) begin
            m_mode = 0; m_phase = 0; m_cnt = 0; m_op = '0; m_hflag = 0;
        end else if (m_mode == 0) begin
            if (start && !load_en) begin
                m_mode = 1; m_phase = 0; m_hflag = 0;
            end
        end else if (m_mode == 2) begin
            if (load_en) m_mode = 0;
        end else begin
            if (m_phase == 1) begin
                m_op = op_code; m_hflag = halt_op;
            end
            if (m_phase < 3) begin
                m_phase++;
            end else begin
                m_cnt++;
                if (m_hflag || pc_max) m_mode = 2;
                else if (load_en) m_mode = 0;
`ifdef SEQ_CTRL_STEP_EN
                else if (step_mode) m_mode = 0;
`endif
                else begin
                    m_phase = 0; m_hflag = 0;
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep();
    endtask

    task automatic checkModel(input string tag);
        logic [2:0] e_st;
        logic [5:0] e_fl;
        e_fl = '0;
        if (m_mode == 0) begin
            e_st = ST_IDLE;
        end else if (m_mode == 2) begin
            e_st = ST_HALT;
            e_fl[0] = 1'b1;
        end else begin
            e_fl[1] = 1'b1;
            case (m_phase)
                0: begin e_st = ST_FETCH;      e_fl[5] = !pc_max; end
                1: begin e_st = ST_DECODE;     e_fl[4] = 1'b1; end
                2: begin e_st = ST_EXEC;       e_fl[3] = 1'b1; end
                default: begin e_st = ST_WRITE_BACK; e_fl[2] = 1'b1; end
            endcase
        end
        checkOutput(tag, e_st, e_fl, m_op,
                    8'((m_cnt > 255) ? 255 : m_cnt),
                    2'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    task automatic resetDut();
        applyStimulus(0, 0, 0, 0, 3'd0, 0, 0);
        advance();
        applyStimulus(0, 0, 0, 0, 3'd0, 0, 0);
        advance();
    endtask

    initial begin
        //            rstn st ld pm op h | state fl(pc,id,acc,rf,busy,halt) oplat c8 c2
        vecs[0]  = mk(1,1,0,0,0,0, 0, 6'b000000, 0, 0, 0);
        vecs[1]  = mk(1,1,0,0,0,0, 1, 6'b100010, 0, 0, 0);
        vecs[2]  = mk(1,1,0,0,5,0, 2, 6'b010010, 0, 0, 0);
        vecs[3]  = mk(1,1,0,0,0,0, 3, 6'b001010, 5, 0, 0);
        vecs[4]  = mk(1,1,0,0,0,0, 4, 6'b000110, 5, 0, 0);
        vecs[5]  = mk(1,1,0,0,0,0, 1, 6'b100010, 5, 1, 1);
        vecs[6]  = mk(1,1,0,0,2,0, 2, 6'b010010, 5, 1, 1);
        vecs[7]  = mk(1,1,0,0,0,0, 3, 6'b001010, 2, 1, 1);
        vecs[8]  = mk(1,1,0,0,0,0, 4, 6'b000110, 2, 1, 1);
        vecs[9]  = mk(1,1,0,0,0,0, 1, 6'b100010, 2, 2, 2);
        vecs[10] = mk(1,1,0,0,7,1, 2, 6'b010010, 2, 2, 2);
        vecs[11] = mk(1,1,0,0,0,0, 3, 6'b001010, 7, 2, 2);
        vecs[12] = mk(1,1,0,0,0,0, 4, 6'b000110, 7, 2, 2);
        vecs[13] = mk(1,1,0,0,0,0, 5, 6'b000001, 7, 3, 3);
        vecs[14] = mk(1,0,0,0,0,0, 5, 6'b000001, 7, 3, 3);
        vecs[15] = mk(1,0,1,0,0,0, 5, 6'b000001, 7, 3, 3);
        vecs[16] = mk(1,1,1,0,0,0, 0, 6'b000000, 7, 3, 3);
        vecs[17] = mk(1,1,1,0,0,0, 0, 6'b000000, 7, 3, 3);
        vecs[18] = mk(1,1,0,0,0,0, 0, 6'b000000, 7, 3, 3);
        vecs[19] = mk(1,1,0,1,0,0, 1, 6'b000010, 7, 3, 3);
        vecs[20] = mk(1,1,0,1,3,0, 2, 6'b010010, 7, 3, 3);
        vecs[21] = mk(1,1,0,1,0,0, 3, 6'b001010, 3, 3, 3);
        vecs[22] = mk(1,1,0,1,0,0, 4, 6'b000110, 3, 3, 3);
        vecs[23] = mk(1,1,0,0,0,0, 5, 6'b000001, 3, 4, 3);
        vecs[24] = mk(1,0,1,0,0,0, 5, 6'b000001, 3, 4, 3);
        vecs[25] = mk(1,1,0,0,0,0, 0, 6'b000000, 3, 4, 3);
        vecs[26] = mk(1,1,0,0,0,0, 1, 6'b100010, 3, 4, 3);
        vecs[27] = mk(1,1,0,0,4,0, 2, 6'b010010, 3, 4, 3);
        vecs[28] = mk(1,1,1,0,0,0, 3, 6'b001010, 4, 4, 3);
        vecs[29] = mk(1,1,1,0,0,0, 4, 6'b000110, 4, 4, 3);
        vecs[30] = mk(1,1,1,0,0,0, 0, 6'b000000, 4, 5, 3);
        vecs[31] = mk(1,1,0,0,0,0, 0, 6'b000000, 4, 5, 3);
        vecs[32] = mk(1,1,0,0,0,0, 1, 6'b100010, 4, 5, 3);
        vecs[33] = mk(1,1,0,0,6,0, 2, 6'b010010, 4, 5, 3);
        vecs[34] = mk(0,1,0,0,0,0, 3, 6'b001010, 6, 5, 3);
        vecs[35] = mk(1,0,0,0,0,0, 0, 6'b000000, 0, 0, 0);

        $display("[TB] directed vector table");
        resetDut();
        for (int i = 0; i < 36; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].start, vecs[i].load_en,
                          vecs[i].pc_max, vecs[i].op, vecs[i].halt, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl,
                        vecs[i].oplat, vecs[i].c8, vecs[i].c2);
            advance();
        end

        $display("[TB] counter saturation run");
        resetDut();
        for (int i = 0; i < 260 * 4 + 1; i++) begin
            applyStimulus(1, 1, 0, 0, 3'(i), 0, 0);
            advance();
        end
        applyStimulus(1, 0, 1, 0, 3'd0, 0, 0);
        checkField("sat_cnt8", 32'(a_cnt), 32'd255);
        checkField("sat_cnt2", 32'(b_cnt), 32'd3);
        checkModel("sat");
        advance();

        $display("[TB] randomized run against reference model");
        resetDut();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 59) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 14) == 0,
                          3'($urandom_range(0, 7)),
                          $urandom_range(0, 11) == 0,
                          1'($urandom_range(0, 1)));
            checkModel($sformatf("rnd%0d", i));
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
